stream_fifo: RTL

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_ram.sv | 23 ++
 rtl/stream_fifo.sv | 98 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the stream FIFO.
package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int afull, input int aempty);
    return (width >= 1) && (depth >= 4) && is_pow2(depth) &&
           (afull >= 1) && (afull <= depth - 1) &&
           (aempty >= 1) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read. Contents are never reset.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with level, almost flags and high-water mark.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] hwm
);

  localparam int PW = ptr_width(DEPTH);
  localparam int LW = lvl_width(DEPTH);

  generate
    if (!params_ok(WIDTH, DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
      $error("stream_fifo: illegal WIDTH/DEPTH/AFULL_LVL/AEMPTY_LVL");
    end
  endgenerate

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d, hwm_q, hwm_d;
  logic [WIDTH-1:0] rd_data;
  logic             push, pop;

  // Handshake flags come only from the registered count, so no input-to-output paths exist.
  assign s_ready = (level_q != LW'(DEPTH));
  assign m_valid = (level_q != '0);
  assign push    = s_valid & s_ready & ~flush;
  assign pop     = m_valid & m_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    hwm_d = (level_d > hwm_q) ? level_d : hwm_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      hwm_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hwm_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hwm_q    <= hwm_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .we_i    (push & ~rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign m_data       = m_valid ? rd_data : '0;
  assign level        = level_q;
  assign hwm          = hwm_q;
  assign almost_full  = (level_q >= LW'(AFULL_LVL));
  assign almost_empty = (level_q <= LW'(AEMPTY_LVL));

endmodule
